// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU stimulus sequencer: opcodes, vector record,
// FSM encoding and the built-in test vector table.
package alu_seq_pkg;

    localparam int unsigned VecDw     = 8;
    localparam int unsigned VecOpw    = 6;
    localparam int unsigned VecTblLen = 8;

    localparam logic [VecOpw-1:0] OpAdd = 6'b100000;
    localparam logic [VecOpw-1:0] OpSub = 6'b100010;
    localparam logic [VecOpw-1:0] OpAnd = 6'b100100;
    localparam logic [VecOpw-1:0] OpOr  = 6'b100101;
    localparam logic [VecOpw-1:0] OpXor = 6'b100110;
    localparam logic [VecOpw-1:0] OpSra = 6'b000011;
    localparam logic [VecOpw-1:0] OpSrl = 6'b000010;
    localparam logic [VecOpw-1:0] OpNor = 6'b100111;

    typedef struct packed {
        logic [VecDw-1:0]  a;
        logic [VecDw-1:0]  b;
        logic [VecOpw-1:0] op;
        logic [VecDw-1:0]  exp;
    } alu_vec_t;

    typedef enum logic [3:0] {
        StIdle, StSetA, StPulseA, StSetB, StPulseB,
        StSetOp, StPulseOp, StWait, StCheck, StDone
    } seq_state_e;

    // Table lookup; indices beyond the table wrap around it.
    function automatic alu_vec_t vec_lookup(input logic [7:0] idx);
        logic [7:0] idx_mod;
        alu_vec_t   v;
        idx_mod = idx % 8'(VecTblLen);
        case (idx_mod)
            8'd0:    v = '{a: 8'h05, b: 8'h03, op: OpAdd, exp: 8'h08};
            8'd1:    v = '{a: 8'h10, b: 8'h01, op: OpSub, exp: 8'h0F};
            8'd2:    v = '{a: 8'hFF, b: 8'hF0, op: OpAnd, exp: 8'hF0};
            8'd3:    v = '{a: 8'h0F, b: 8'h30, op: OpOr,  exp: 8'h3F};
            8'd4:    v = '{a: 8'hAA, b: 8'hFF, op: OpXor, exp: 8'h55};
            8'd5:    v = '{a: 8'h80, b: 8'h02, op: OpSra, exp: 8'hE0};
            8'd6:    v = '{a: 8'h80, b: 8'h02, op: OpSrl, exp: 8'h20};
            8'd7:    v = '{a: 8'h0F, b: 8'hF0, op: OpNor, exp: 8'h00};
            default: v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/alu_vec_rom.sv
// Combinational test vector ROM: index in, {A, B, OP, EXPECTED} record out.
module alu_vec_rom
    import alu_seq_pkg::*;
(
    input  logic [7:0] idx_i,
    output alu_vec_t   vec_o
);

    // Pure lookup into the package table.
    always_comb begin
        vec_o = vec_lookup(idx_i);
    end

endmodule

// File: rtl/alu_stim_sequencer.sv
// Drives an ALU toplevel through its switch/button interface, one stored
// vector at a time, and compares the LED result against the expected value.
// Optional build macro: SEQ_STOP_ON_FAIL_EN -- stop the run on the first
// mismatch, leaving o_vec_idx at the failing vector.
module alu_stim_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned NB_DATA   = 8,
    parameter int unsigned NB_OP     = 6,
    parameter int unsigned N_VEC     = 8,
    parameter int unsigned SETUP_CYC = 2,
    parameter int unsigned PULSE_CYC = 2,
    parameter int unsigned WAIT_CYC  = 4
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic [NB_DATA-1:0] i_led,
    output logic [NB_DATA-1:0] o_sw,
    output logic               o_btnL,
    output logic               o_btnR,
    output logic               o_btnC,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_pass,
    output logic [7:0]         o_err_count,
    output logic [7:0]         o_vec_idx
);

    localparam int unsigned MaxSp  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int unsigned MaxCyc = (MaxSp > WAIT_CYC) ? MaxSp : WAIT_CYC;
    localparam int unsigned CntW   = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;
    localparam logic [7:0]  LastIdx = 8'(N_VEC - 1);

    seq_state_e        state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [7:0]        idx_q, idx_d;
    logic [7:0]        err_q, err_d;
    logic              pass_q, pass_d;

    alu_vec_t          vec;
    logic [NB_DATA-1:0] a_ext, b_ext, op_ext, exp_ext;
    logic              mismatch;

    alu_vec_rom u_rom (
        .idx_i (idx_q),
        .vec_o (vec)
    );

    // Fit the fixed-width table fields onto the configured bus widths.
    always_comb begin
        a_ext    = NB_DATA'(vec.a);
        b_ext    = NB_DATA'(vec.b);
        op_ext   = NB_DATA'(NB_OP'(vec.op));
        exp_ext  = NB_DATA'(vec.exp);
        mismatch = (i_led != exp_ext);
    end

    // Duration reload for the shared phase counter (counts down to zero).
    function automatic logic [CntW-1:0] cnt_load(input seq_state_e st);
        case (st)
            StSetA, StSetB, StSetOp:       return CntW'(SETUP_CYC - 1);
            StPulseA, StPulseB, StPulseOp: return CntW'(PULSE_CYC - 1);
            StWait:                        return CntW'(WAIT_CYC - 1);
            default:                       return '0;
        endcase
    endfunction

    // Successor of each timed phase.
    function automatic seq_state_e timed_next(input seq_state_e st);
        case (st)
            StSetA:    return StPulseA;
            StPulseA:  return StSetB;
            StSetB:    return StPulseB;
            StPulseB:  return StSetOp;
            StSetOp:   return StPulseOp;
            StPulseOp: return StWait;
            default:   return StCheck;
        endcase
    endfunction

    // State register and shared phase counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Run bookkeeping: vector index, error count and pass flag.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            idx_q  <= '0;
            err_q  <= '0;
            pass_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            err_q  <= err_d;
            pass_q <= pass_d;
        end
    end

    // Next-state, counter and bookkeeping logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        err_d   = err_q;
        pass_d  = pass_q;
        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    state_d = StSetA;
                    cnt_d   = cnt_load(StSetA);
                    idx_d   = '0;
                    err_d   = '0;
                    pass_d  = 1'b1;
                end
            end
            StSetA, StPulseA, StSetB, StPulseB, StSetOp, StPulseOp, StWait: begin
                if (cnt_q == '0) begin
                    state_d = timed_next(state_q);
                    cnt_d   = cnt_load(timed_next(state_q));
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StCheck: begin
                if (mismatch) begin
                    pass_d = 1'b0;
                    if (err_q != 8'hFF) begin
                        err_d = err_q + 8'd1;
                    end
                end
`ifdef SEQ_STOP_ON_FAIL_EN
                if (mismatch || idx_q >= LastIdx) begin
`else
                if (idx_q >= LastIdx) begin
`endif
                    state_d = StDone;
                end else begin
                    state_d = StSetA;
                    cnt_d   = cnt_load(StSetA);
                    idx_d   = idx_q + 8'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // Decode switch/button/status outputs from the current state.
    always_comb begin
        o_sw   = '0;
        o_btnL = 1'b0;
        o_btnR = 1'b0;
        o_btnC = 1'b0;
        o_busy = (state_q != StIdle);
        o_done = (state_q == StDone);
        unique case (state_q)
            StSetA:    o_sw = a_ext;
            StPulseA: begin
                o_sw   = a_ext;
                o_btnL = 1'b1;
            end
            StSetB:    o_sw = b_ext;
            StPulseB: begin
                o_sw   = b_ext;
                o_btnR = 1'b1;
            end
            StSetOp:   o_sw = op_ext;
            StPulseOp: begin
                o_sw   = op_ext;
                o_btnC = 1'b1;
            end
            StWait, StCheck: o_sw = op_ext;
            default:   o_sw = '0;
        endcase
    end

    assign o_pass      = pass_q;
    assign o_err_count = err_q;
    assign o_vec_idx   = idx_q;

endmodule

// File: tb/tb_alu_stim_sequencer.sv
// Self-checking bench for alu_stim_sequencer with a behavioural ALU toplevel
// model attached to the switch/button/LED interface.
module tb_alu_stim_sequencer;

    localparam int NB_DATA   = 8;
    localparam int NB_OP     = 6;
    localparam int N_VEC     = 8;
    localparam int SETUP_CYC = 2;
    localparam int PULSE_CYC = 2;
    localparam int WAIT_CYC  = 4;
    localparam int PER       = 3 * SETUP_CYC + 3 * PULSE_CYC + WAIT_CYC + 1;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [5:0] op;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl [N_VEC];

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [7:0]   led;
    logic [7:0]   sw;
    logic         btn_l, btn_r, btn_c, busy, done, pass;
    logic [7:0]   err_count, vec_idx;

    int n_checks = 0;
    int n_fail   = 0;
    int led_mode = 0;
    int loaded_vecs = 0;

    alu_stim_sequencer #(
        .NB_DATA   (NB_DATA),
        .NB_OP     (NB_OP),
        .N_VEC     (N_VEC),
        .SETUP_CYC (SETUP_CYC),
        .PULSE_CYC (PULSE_CYC),
        .WAIT_CYC  (WAIT_CYC)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_led       (led),
        .o_sw        (sw),
        .o_btnL      (btn_l),
        .o_btnR      (btn_r),
        .o_btnC      (btn_c),
        .o_busy      (busy),
        .o_done      (done),
        .o_pass      (pass),
        .o_err_count (err_count),
        .o_vec_idx   (vec_idx)
    );

    always #5 clk = ~clk;

    // Behavioural ALU toplevel: buttons latch operands/opcode from the switches.
    logic [7:0] m_a, m_b;
    logic [5:0] m_op;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_a  <= '0;
            m_b  <= '0;
            m_op <= '0;
        end else begin
            if (btn_l) m_a <= sw;
            if (btn_r) m_b <= sw;
            if (btn_c) m_op <= sw[5:0];
        end
    end

    function automatic logic [7:0] alu(input logic [7:0] a, input logic [7:0] b,
                                       input logic [5:0] op);
        case (op)
            6'b100000: return a + b;
            6'b100010: return a - b;
            6'b100100: return a & b;
            6'b100101: return a | b;
            6'b100110: return a ^ b;
            6'b000011: return 8'($signed(a) >>> b);
            6'b000010: return a >> b;
            6'b100111: return ~(a | b);
            default:   return 8'h00;
        endcase
    endfunction

    // Mode 0: golden; mode 1: LEDs stuck at 00; mode 2: corrupt vector 3 only.
    always_comb begin
        led = alu(m_a, m_b, m_op);
        if (led_mode == 1) led = 8'h00;
        else if (led_mode == 2 && loaded_vecs == 4) led = led ^ 8'h01;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One full run; checks switch values at every button pulse.
    task automatic run_seq(input int mode, input bit hold, output int cycles, output int n_done);
        bit seen;
        bit c_prev;
        int post;
        led_mode    = mode;
        loaded_vecs = 0;
        n_done      = 0;
        seen        = 1'b0;
        c_prev      = 1'b0;
        post        = 0;
        @(negedge clk);
        start  = 1'b1;
        cycles = 1;
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk);
            #1;
            if (!hold) start = 1'b0;
            if (!seen) cycles++;
            if (c_prev && !btn_c) loaded_vecs++;
            c_prev = btn_c;
            if ((btn_l || btn_r || btn_c) && loaded_vecs < N_VEC) begin
                check("one_button", 32'($countones({btn_l, btn_r, btn_c})), 32'd1);
                check("vec_idx_at_pulse", vec_idx, loaded_vecs);
                if (btn_l) check("sw_during_btnL", sw, tbl[loaded_vecs].a);
                if (btn_r) check("sw_during_btnR", sw, tbl[loaded_vecs].b);
                if (btn_c) check("sw_during_btnC", sw, {2'b00, tbl[loaded_vecs].op});
            end
            if (done) begin
                n_done++;
                if (!seen) begin
                    seen  = 1'b1;
                    start = 1'b0;
                end
            end else if (!seen && (c % 16) == 0) begin
                check("busy_while_running", busy, 1'b1);
            end
            if (seen) begin
                if (post == 1) check("idle_after_done", busy, 1'b0);
                if (post == 3) break;
                post++;
            end
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL run_timeout: got no o_done, expected o_done within budget");
        end
    endtask

    initial begin
        int cyc;
        int nd;
        int exp_idx;
        bit found;

        tbl[0] = '{a: 8'h05, b: 8'h03, op: 6'b100000, exp: 8'h08};
        tbl[1] = '{a: 8'h10, b: 8'h01, op: 6'b100010, exp: 8'h0F};
        tbl[2] = '{a: 8'hFF, b: 8'hF0, op: 6'b100100, exp: 8'hF0};
        tbl[3] = '{a: 8'h0F, b: 8'h30, op: 6'b100101, exp: 8'h3F};
        tbl[4] = '{a: 8'hAA, b: 8'hFF, op: 6'b100110, exp: 8'h55};
        tbl[5] = '{a: 8'h80, b: 8'h02, op: 6'b000011, exp: 8'hE0};
        tbl[6] = '{a: 8'h80, b: 8'h02, op: 6'b000010, exp: 8'h20};
        tbl[7] = '{a: 8'h0F, b: 8'hF0, op: 6'b100111, exp: 8'h00};

        // Reset state.
        #1;
        check("rst_sw", sw, 8'h00);
        check("rst_buttons", {btn_l, btn_r, btn_c}, 3'b000);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_pass", pass, 1'b0);
        check("rst_err", err_count, 8'h00);
        check("rst_idx", vec_idx, 8'h00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_busy", busy, 1'b0);

        // Golden run: latency, pass, no errors.
        run_seq(0, 1'b0, cyc, nd);
        check("golden_latency", cyc, N_VEC * PER + 2);
        check("golden_done_count", nd, 1);
        check("golden_err", err_count, 8'h00);
        check("golden_pass", pass, 1'b1);
        check("golden_last_idx", vec_idx, N_VEC - 1);

        // LEDs stuck at zero: only the NOR vector (expects 00) passes.
        run_seq(1, 1'b0, cyc, nd);
        check("stuck0_err", err_count, 8'd7);
        check("stuck0_pass", pass, 1'b0);
        @(negedge clk);
        check("stuck0_err_hold", err_count, 8'd7);

        // Single mismatch at vector 3.
`ifdef SEQ_STOP_ON_FAIL_EN
        exp_idx = 3;
`else
        exp_idx = N_VEC - 1;
`endif
        run_seq(2, 1'b0, cyc, nd);
        check("one_bad_err", err_count, 8'd1);
        check("one_bad_idx", vec_idx, exp_idx);
        check("one_bad_pass", pass, 1'b0);

        // Reset asserted during PULSE_B aborts at once.
        led_mode = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk);
            #1;
            if (btn_r) begin
                found = 1'b1;
                break;
            end
        end
        check("reached_pulse_b", found, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_buttons", {btn_l, btn_r, btn_c}, 3'b000);
        check("abort_busy", busy, 1'b0);
        check("abort_sw", sw, 8'h00);
        check("abort_err", err_count, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Restart after abort begins at vector 0 and completes cleanly.
        run_seq(0, 1'b0, cyc, nd);
        check("restart_latency", cyc, N_VEC * PER + 2);
        check("restart_err", err_count, 8'h00);
        check("restart_pass", pass, 1'b1);

        // Start held high for the whole run: one o_done, no early restart.
        run_seq(0, 1'b1, cyc, nd);
        check("hold_latency", cyc, N_VEC * PER + 2);
        check("hold_done_count", nd, 1);
        check("hold_pass", pass, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
